// File: rtl/gtech_seq_pkg.sv
// Shared definitions for the GTECH sequential stream blocks: occupancy
// state encoding for the 2-entry skid buffer and default widths.
package gtech_seq_pkg;

    // Buffer occupancy: number of words currently held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/gtech_skid_buf.sv
// Two-entry valid/ready skid buffer. in_ready and out_valid are registered
// from the next occupancy, so there is no combinational path from
// out_ready to in_ready. The head register drives out_data directly.
module gtech_skid_buf
    import gtech_seq_pkg::*;
#(
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    occ_state_t    state;
    occ_state_t    state_nxt;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = head_q;

    // Next occupancy from the two handshakes.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (in_fire) state_nxt = ONE;
            end
            ONE: begin
                if (in_fire && !out_fire)      state_nxt = TWO;
                else if (!in_fire && out_fire) state_nxt = EMPTY;
            end
            TWO: begin
                if (out_fire) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Occupancy, registered handshake outputs and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            head_q    <= '0;
            skid_q    <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != TWO);
            out_valid <= (state_nxt != EMPTY);
            unique case (state)
                EMPTY: begin
                    if (in_fire) head_q <= in_data;
                end
                ONE: begin
                    // Simultaneous accept and drain replaces the head in place.
                    if (in_fire && out_fire) head_q <= in_data;
                    else if (in_fire)        skid_q <= in_data;
                end
                TWO: begin
                    if (out_fire) head_q <= skid_q;
                end
                default: begin
                    head_q <= head_q;
                end
            endcase
        end
    end

endmodule

// File: rtl/gtech_or_not_stream.sv
// Flow-controlled vector OR-NOT: Z = A | ~B per bit, with a flag and a
// saturating counter for words violating the implication (Z not all-ones).
// Z and the flag are computed on the input side and buffered together.
module gtech_or_not_stream
    import gtech_seq_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [W-1:0]     IN_A,
    input  logic [W-1:0]     IN_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [W-1:0]     OUT_Z,
    output logic             OUT_VIOL,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] VIOL_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0] z;
    logic         viol;
    logic         in_fire;
    logic [W:0]   head;

    assign z       = IN_A | ~IN_B;
    assign viol    = ~&z;
    assign in_fire = IN_VALID & IN_READY;

    gtech_skid_buf #(
        .DW (W + 1)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RST_N),
        .in_valid  (IN_VALID),
        .in_ready  (IN_READY),
        .in_data   ({viol, z}),
        .out_valid (OUT_VALID),
        .out_ready (OUT_READY),
        .out_data  (head)
    );

    assign OUT_Z    = head[W-1:0];
    assign OUT_VIOL = head[W] & OUT_VALID;

    // Saturating violation counter; clear wins over a same-cycle increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VIOL_CNT <= '0;
        end else if (CNT_CLR) begin
            VIOL_CNT <= '0;
        end else if (in_fire && viol && (VIOL_CNT != '1)) begin
            VIOL_CNT <= VIOL_CNT + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_gtech_or_not_stream.sv
module tb_gtech_or_not_stream;

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  IN_A;
    logic [7:0]  IN_B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [7:0]  OUT_Z;
    logic        OUT_VIOL;
    logic        CNT_CLR;
    logic [15:0] VIOL_CNT;

    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_z2;
    logic        out_viol2;
    logic [1:0]  viol_cnt2;

    gtech_or_not_stream #(.W(8), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_Z(OUT_Z), .OUT_VIOL(OUT_VIOL), .CNT_CLR(CNT_CLR), .VIOL_CNT(VIOL_CNT)
    );

    gtech_or_not_stream #(.W(8), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_ready2),
        .IN_A(IN_A), .IN_B(IN_B), .OUT_VALID(out_valid2), .OUT_READY(OUT_READY),
        .OUT_Z(out_z2), .OUT_VIOL(out_viol2), .CNT_CLR(CNT_CLR), .VIOL_CNT(viol_cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: ordered list of words in flight plus saturating counts.
    typedef struct {
        logic [7:0] z;
        logic       v;
    } ent_t;

    ent_t        q[$];
    int unsigned cnt;
    int unsigned cnt2;
    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  z;
        logic        v;
        logic [15:0] c;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance, update the reference, compare everything.
    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy, input logic clr);
        bit         in_fire;
        bit         out_fire;
        ent_t       e;
        IN_VALID  = iv;
        IN_A      = iv ? a : 8'hxx;
        IN_B      = iv ? b : 8'hxx;
        OUT_READY = ordy;
        CNT_CLR   = clr;
        in_fire   = iv && (q.size() < 2);
        out_fire  = ordy && (q.size() > 0);
        e.z = a | ~b;
        e.v = (e.z != 8'hFF);
        @(posedge CLK);
        #1;
        if (out_fire) void'(q.pop_front());
        if (in_fire)  q.push_back(e);
        if (clr) begin
            cnt  = 0;
            cnt2 = 0;
        end else if (in_fire && e.v) begin
            if (cnt < 65535) cnt++;
            if (cnt2 < 3)    cnt2++;
        end
        chk("in_ready",   {31'd0, IN_READY},   {31'd0, q.size() < 2});
        chk("out_valid",  {31'd0, OUT_VALID},  {31'd0, q.size() > 0});
        chk("in_ready2",  {31'd0, in_ready2},  {31'd0, q.size() < 2});
        chk("out_valid2", {31'd0, out_valid2}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("out_z",    {24'd0, OUT_Z},      {24'd0, q[0].z});
            chk("out_viol", {31'd0, OUT_VIOL},   {31'd0, q[0].v});
            chk("out_z2",   {24'd0, out_z2},     {24'd0, q[0].z});
        end else begin
            chk("out_viol_idle", {31'd0, OUT_VIOL}, 32'd0);
        end
        chk("viol_cnt",  {16'd0, VIOL_CNT},  cnt);
        chk("viol_cnt2", {30'd0, viol_cnt2}, cnt2);
    endtask

    task automatic do_reset();
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        CNT_CLR   = 1'b0;
        RST_N     = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_viol_cnt",  {16'd0, VIOL_CNT},  32'd0);
        chk("rst_in_ready",  {31'd0, IN_READY},  32'd0);
        chk("rst_out_z",     {24'd0, OUT_Z},     32'd0);
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        #1;
        chk("rel_in_ready_low", {31'd0, IN_READY}, 32'd0);
        q.delete();
        cnt  = 0;
        cnt2 = 0;
        @(posedge CLK);
        #1;
        chk("rel_in_ready", {31'd0, IN_READY},  32'd1);
        chk("rel_no_stale", {31'd0, OUT_VALID}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cnt       = 0;
        cnt2      = 0;
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_A      = '0;
        IN_B      = '0;
        OUT_READY = 1'b0;
        CNT_CLR   = 1'b0;

        vecs[0] = '{8'h0F, 8'hF0, 8'h0F, 1'b1, 16'd1};
        vecs[1] = '{8'h00, 8'h00, 8'hFF, 1'b0, 16'd1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 16'd1};
        vecs[3] = '{8'h00, 8'hFF, 8'h00, 1'b1, 16'd2};
        vecs[4] = '{8'hAA, 8'h55, 8'hAA, 1'b1, 16'd3};
        vecs[5] = '{8'h55, 8'hAA, 8'h55, 1'b1, 16'd4};
        vecs[6] = '{8'h01, 8'h01, 8'hFF, 1'b0, 16'd4};
        vecs[7] = '{8'h12, 8'h34, 8'hDB, 1'b1, 16'd5};

        do_reset();

        // Single-word vectors with gaps, against hand-computed constants.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
            chk("vec_z",    {24'd0, OUT_Z},    {24'd0, vecs[i].z});
            chk("vec_viol", {31'd0, OUT_VIOL}, {31'd0, vecs[i].v});
            chk("vec_cnt",  {16'd0, VIOL_CNT}, {16'd0, vecs[i].c});
            cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            chk("vec_drain", {31'd0, OUT_VALID}, 32'd0);
        end

        // Back-pressure: third word waits until the consumer drains.
        cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        chk("bp_ready_one", {31'd0, IN_READY}, 32'd1);
        cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
        chk("bp_ready_full", {31'd0, IN_READY}, 32'd0);
        cycle(1'b1, 8'h55, 8'h66, 1'b0, 1'b0);
        chk("bp_head_held", {24'd0, OUT_Z}, 32'h000000DD);
        cycle(1'b1, 8'h55, 8'h66, 1'b1, 1'b0);
        chk("bp_second", {24'd0, OUT_Z}, 32'h000000BB);
        cycle(1'b1, 8'h55, 8'h66, 1'b1, 1'b0);
        chk("bp_third", {24'd0, OUT_Z}, 32'h000000DD);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("bp_empty", {31'd0, OUT_VALID}, 32'd0);

        // Reset with two words buffered.
        cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("rst_no_stale_later", {31'd0, OUT_VALID}, 32'd0);

        // Full throughput.
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Saturation on the 2-bit counter, then clear against an increment.
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 8'h00, 8'hFF, 1'b1, 1'b0);
        chk("sat_cnt2", {30'd0, viol_cnt2}, 32'd3);
        chk("sat_cnt",  {16'd0, VIOL_CNT},  32'd5);
        cycle(1'b1, 8'h00, 8'hFF, 1'b1, 1'b0);
        chk("sat_hold", {30'd0, viol_cnt2}, 32'd3);
        cycle(1'b1, 8'h00, 8'hFF, 1'b1, 1'b1);
        chk("clr_cnt2", {30'd0, viol_cnt2}, 32'd0);
        chk("clr_cnt",  {16'd0, VIOL_CNT},  32'd0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Random valid/ready toggling.
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 63) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
